// File: rtl/fd_grad_engine.sv
// Finite-difference gradient sequencer: drives an external objective evaluator per coefficient
// and streams saturated fixed-point gradients in central or forward mode.
module fd_grad_engine #(
    parameter int NUM_ELEMENTS = 50,
    parameter int DATA_WIDTH   = 32,
    parameter int STEP_LOG2    = 10,
    parameter int IDX_W        = (NUM_ELEMENTS > 1) ? $clog2(NUM_ELEMENTS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  mode,
    output logic                  busy,
    output logic                  done,
    output logic                  eval_req_valid,
    input  logic                  eval_req_ready,
    output logic [IDX_W-1:0]      eval_idx,
    output logic [1:0]            eval_dir,
    input  logic                  eval_rsp_valid,
    input  logic [DATA_WIDTH-1:0] eval_rsp_data,
    output logic                  grad_valid,
    input  logic                  grad_ready,
    output logic [DATA_WIDTH-1:0] grad_data,
    output logic [IDX_W-1:0]      grad_idx,
    output logic                  grad_last,
    output logic [DATA_WIDTH-1:0] f0_data
);

    // state      | meaning
    // IDLE       | waiting for start
    // REQ_BASE   | requesting unperturbed objective (forward mode only)
    // WAIT_BASE  | waiting for unperturbed objective
    // REQ_P      | requesting +h objective for current idx
    // WAIT_P     | waiting for +h objective
    // REQ_M      | requesting -h objective (central mode only)
    // WAIT_M     | waiting for -h objective
    // CALC       | difference, shift, saturate into grad_data
    // OUT        | presenting gradient until accepted
    // FIN        | one-cycle done pulse
    typedef enum logic [3:0] {
        IDLE, REQ_BASE, WAIT_BASE, REQ_P, WAIT_P, REQ_M, WAIT_M, CALC, OUT, FIN
    } state_t;

    localparam int                      WW       = DATA_WIDTH + 1 + STEP_LOG2;
    localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(NUM_ELEMENTS - 1);
    localparam logic [DATA_WIDTH-1:0]   SAT_MAX  = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0]   SAT_MIN  = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    state_t                  state, state_nxt;
    logic                    mode_r;
    logic [IDX_W-1:0]        idx;
    logic [DATA_WIDTH-1:0]   f0, fp, fm, grad_r;
    logic [DATA_WIDTH:0]     diff;
    logic signed [WW-1:0]    diff_ext, g_wide;
    logic                    ovf;
    logic [DATA_WIDTH-1:0]   g_sat;
    logic                    is_last;

    assign is_last = (idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (start)          state_nxt = mode ? REQ_BASE : REQ_P;
            REQ_BASE:  if (eval_req_ready) state_nxt = WAIT_BASE;
            WAIT_BASE: if (eval_rsp_valid) state_nxt = REQ_P;
            REQ_P:     if (eval_req_ready) state_nxt = WAIT_P;
            WAIT_P:    if (eval_rsp_valid) state_nxt = mode_r ? CALC : REQ_M;
            REQ_M:     if (eval_req_ready) state_nxt = WAIT_M;
            WAIT_M:    if (eval_rsp_valid) state_nxt = CALC;
            CALC:                          state_nxt = OUT;
            OUT:       if (grad_ready)     state_nxt = is_last ? FIN : REQ_P;
            FIN:                           state_nxt = IDLE;
            default:                       state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy           = 1'b0;
        done           = 1'b0;
        eval_req_valid = 1'b0;
        eval_idx       = '0;
        eval_dir       = 2'b00;
        grad_valid     = 1'b0;
        grad_idx       = '0;
        grad_last      = 1'b0;
        case (state)
            IDLE: ;
            REQ_BASE: begin
                busy           = 1'b1;
                eval_req_valid = 1'b1;
            end
            REQ_P: begin
                busy           = 1'b1;
                eval_req_valid = 1'b1;
                eval_idx       = idx;
                eval_dir       = 2'b01;
            end
            REQ_M: begin
                busy           = 1'b1;
                eval_req_valid = 1'b1;
                eval_idx       = idx;
                eval_dir       = 2'b10;
            end
            OUT: begin
                busy       = 1'b1;
                grad_valid = 1'b1;
                grad_idx   = idx;
                grad_last  = is_last;
            end
            FIN: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: busy = 1'b1;
        endcase
    end

    // One extra bit keeps the difference exact; widening by STEP_LOG2 keeps the shift exact before clamping.
    always_comb begin
        diff     = mode_r ? ({fp[DATA_WIDTH-1], fp} - {f0[DATA_WIDTH-1], f0})
                          : ({fp[DATA_WIDTH-1], fp} - {fm[DATA_WIDTH-1], fm});
        diff_ext = {{STEP_LOG2{diff[DATA_WIDTH]}}, diff};
        g_wide   = mode_r ? (diff_ext <<< STEP_LOG2) : (diff_ext <<< (STEP_LOG2 - 1));
        ovf      = (g_wide[WW-1:DATA_WIDTH-1] != '0) && (g_wide[WW-1:DATA_WIDTH-1] != '1);
        g_sat    = ovf ? (g_wide[WW-1] ? SAT_MIN : SAT_MAX) : g_wide[DATA_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mode_r <= 1'b0;
            idx    <= '0;
            f0     <= '0;
            fp     <= '0;
            fm     <= '0;
            grad_r <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    mode_r <= mode;
                    idx    <= '0;
                end
                WAIT_BASE: if (eval_rsp_valid) f0 <= eval_rsp_data;
                WAIT_P:    if (eval_rsp_valid) fp <= eval_rsp_data;
                WAIT_M:    if (eval_rsp_valid) fm <= eval_rsp_data;
                CALC:      grad_r <= g_sat;
                OUT:       if (grad_ready && !is_last) idx <= idx + 1'b1;
                default: ;
            endcase
        end
    end

    assign grad_data = grad_r;
    assign f0_data   = f0;

endmodule

// File: tb/tb_fd_grad_engine.sv
// Bench for fd_grad_engine: directed and random sweeps served by a sequential evaluator,
// checked against an arithmetic gradient model.
module tb_fd_grad_engine;
    localparam int N  = 3;
    localparam int DW = 16;
    localparam int SL = 4;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0, start1 = 1'b0, mode = 1'b0;
    logic eval_req_ready = 1'b0, eval_rsp_valid = 1'b0, grad_ready = 1'b0;
    logic [DW-1:0] eval_rsp_data = '0;

    logic          busy, done, eval_req_valid, grad_valid, grad_last;
    logic [IW-1:0] eval_idx, grad_idx;
    logic [1:0]    eval_dir;
    logic [DW-1:0] grad_data, f0_data;

    logic          busy1, done1, eval_req_valid1, grad_valid1, grad_last1;
    logic [0:0]    eval_idx1, grad_idx1;
    logic [1:0]    eval_dir1;
    logic [DW-1:0] grad_data1, f0_data1;

    int vectors = 0;
    int miscompares = 0;
    longint base_v;
    longint pv[N];
    longint mv[N];

    fd_grad_engine #(.NUM_ELEMENTS(N), .DATA_WIDTH(DW), .STEP_LOG2(SL)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .busy(busy), .done(done),
        .eval_req_valid(eval_req_valid), .eval_req_ready(eval_req_ready),
        .eval_idx(eval_idx), .eval_dir(eval_dir), .eval_rsp_valid(eval_rsp_valid),
        .eval_rsp_data(eval_rsp_data), .grad_valid(grad_valid), .grad_ready(grad_ready),
        .grad_data(grad_data), .grad_idx(grad_idx), .grad_last(grad_last), .f0_data(f0_data)
    );

    fd_grad_engine #(.NUM_ELEMENTS(1), .DATA_WIDTH(DW), .STEP_LOG2(SL)) u_one (
        .clk(clk), .rst(rst), .start(start1), .mode(mode), .busy(busy1), .done(done1),
        .eval_req_valid(eval_req_valid1), .eval_req_ready(eval_req_ready),
        .eval_idx(eval_idx1), .eval_dir(eval_dir1), .eval_rsp_valid(eval_rsp_valid),
        .eval_rsp_data(eval_rsp_data), .grad_valid(grad_valid1), .grad_ready(grad_ready),
        .grad_data(grad_data1), .grad_idx(grad_idx1), .grad_last(grad_last1), .f0_data(f0_data1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Gradient = (f(+h) - reference) / h, with h = 2^-SL; central divides by 2h.
    function automatic longint model_grad(input longint a, input longint b, input bit fwd);
        longint g;
        g = (a - b) * (longint'(1) << (fwd ? SL : SL - 1));
        if (g >  32767) g =  32767;
        if (g < -32768) g = -32768;
        return g;
    endfunction

    function automatic longint rnd16();
        logic [15:0] r;
        r = 16'($urandom);
        return longint'($signed(r));
    endfunction

    task automatic serve(input string tag, input int exp_idx, input int exp_dir,
                         input longint data, input bit bp, input bit poke);
        int t = 0;
        int lat;
        while (eval_req_valid !== 1'b1 && t < 50) begin step(); t++; end
        chk({tag, " req_valid"}, eval_req_valid, 1);
        chk({tag, " eval_idx"}, eval_idx, exp_idx);
        chk({tag, " eval_dir"}, eval_dir, exp_dir);
        if (bp) begin
            for (int k = 0; k < 3; k++) begin
                step();
                chk({tag, " req_hold_valid"}, eval_req_valid, 1);
                chk({tag, " req_hold_idx"}, eval_idx, exp_idx);
                chk({tag, " req_hold_dir"}, eval_dir, exp_dir);
            end
        end
        if (poke) begin start = 1'b1; mode = ~mode; end
        eval_req_ready = 1'b1;
        step();
        eval_req_ready = 1'b0;
        start = 1'b0;
        chk({tag, " req_drop"}, eval_req_valid, 0);
        lat = $urandom_range(0, 2);
        repeat (lat) step();
        eval_rsp_valid = 1'b1;
        eval_rsp_data = 16'(data);
        step();
        eval_rsp_valid = 1'b0;
    endtask

    task automatic take_grad(input int i, input longint exp, input bit bp);
        int t = 0;
        while (grad_valid !== 1'b1 && t < 50) begin step(); t++; end
        chk("grad_valid", grad_valid, 1);
        chk("grad_data", $signed(grad_data), exp);
        chk("grad_idx", grad_idx, i);
        chk("grad_last", grad_last, (i == N - 1) ? 1 : 0);
        if (bp) begin
            for (int k = 0; k < 5; k++) begin
                step();
                chk("bp_grad_valid", grad_valid, 1);
                chk("bp_grad_data", $signed(grad_data), exp);
                chk("bp_grad_idx", grad_idx, i);
                chk("bp_no_req", eval_req_valid, 0);
            end
        end
        grad_ready = 1'b1;
        step();
        grad_ready = 1'b0;
        if (i == N - 1) begin
            chk("done_pulse", done, 1);
            step();
            chk("done_clear", done, 0);
            chk("busy_clear", busy, 0);
        end else begin
            chk("done_early", done, 0);
        end
    endtask

    task automatic sweep(input bit md, input bit bp, input bit poke);
        mode = md;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("busy_rise", busy, 1);
        chk("req_rise", eval_req_valid, 1);
        if (md) serve("base", 0, 0, base_v, bp, 1'b0);
        for (int i = 0; i < N; i++) begin
            serve("plus", i, 1, pv[i], bp, poke && (i == 1));
            if (!md) serve("minus", i, 2, mv[i], bp, 1'b0);
            take_grad(i, model_grad(pv[i], md ? base_v : mv[i], md), bp && (i == 1));
        end
        if (md) chk("f0_data", $signed(f0_data), base_v);
    endtask

    task automatic zero_latency(input bit md, input int exp_cycles);
        int cyc = 1;
        eval_req_ready = 1'b1;
        eval_rsp_valid = 1'b1;
        eval_rsp_data  = 16'd100;
        grad_ready     = 1'b1;
        mode  = md;
        start = 1'b1;
        start1 = !md;
        step();
        start = 1'b0;
        start1 = 1'b0;
        while (done !== 1'b1 && cyc < 100) begin
            if (!md && cyc == 6) begin
                chk("one_grad_valid", grad_valid1, 1);
                chk("one_grad_last", grad_last1, 1);
                chk("one_grad_idx", grad_idx1, 0);
            end
            if (!md && cyc == 7) chk("one_done", done1, 1);
            step();
            cyc++;
        end
        chk(md ? "fwd_cycles" : "cen_cycles", cyc, exp_cycles);
        eval_req_ready = 1'b0;
        eval_rsp_valid = 1'b0;
        grad_ready     = 1'b0;
        step();
        step();
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " done"}, done, 0);
        chk({tag, " req_valid"}, eval_req_valid, 0);
        chk({tag, " eval_idx"}, eval_idx, 0);
        chk({tag, " eval_dir"}, eval_dir, 0);
        chk({tag, " grad_valid"}, grad_valid, 0);
        chk({tag, " grad_data"}, grad_data, 0);
        chk({tag, " grad_idx"}, grad_idx, 0);
        chk({tag, " grad_last"}, grad_last, 0);
        chk({tag, " f0_data"}, f0_data, 0);
    endtask

    initial begin
        int t;
        repeat (3) step();
        check_quiet("reset");
        chk("one_reset", {busy1, done1, eval_req_valid1, eval_idx1, eval_dir1, grad_valid1,
                          grad_data1, grad_idx1, grad_last1, f0_data1}, 0);
        rst = 1'b1;
        step();

        for (int i = 0; i < N; i++) begin pv[i] = 100; mv[i] = 96; end
        sweep(1'b0, 1'b0, 1'b0);

        base_v = 50; pv[0] = 53; pv[1] = 49; pv[2] = 50;
        sweep(1'b1, 1'b0, 1'b0);

        pv[0] = 32767;  mv[0] = -32768;
        pv[1] = -32768; mv[1] = 32767;
        pv[2] = rnd16(); mv[2] = rnd16();
        sweep(1'b0, 1'b0, 1'b0);

        for (int i = 0; i < N; i++) begin pv[i] = rnd16(); mv[i] = rnd16(); end
        sweep(1'b0, 1'b1, 1'b0);
        base_v = rnd16();
        for (int i = 0; i < N; i++) pv[i] = base_v + $signed(4'($urandom)) * 64;
        for (int i = 0; i < N; i++) if (pv[i] > 32767 || pv[i] < -32768) pv[i] = base_v;
        sweep(1'b1, 1'b1, 1'b0);

        for (int i = 0; i < N; i++) begin pv[i] = rnd16(); mv[i] = pv[i] - 40 + $urandom_range(0, 80); end
        for (int i = 0; i < N; i++) if (mv[i] > 32767 || mv[i] < -32768) mv[i] = pv[i];
        sweep(1'b0, 1'b0, 1'b1);
        base_v = rnd16();
        for (int i = 0; i < N; i++) pv[i] = rnd16();
        sweep(1'b1, 1'b0, 1'b1);

        for (int r = 0; r < 4; r++) begin
            base_v = rnd16();
            for (int i = 0; i < N; i++) begin pv[i] = rnd16(); mv[i] = rnd16(); end
            sweep(1'($urandom), 1'($urandom), 1'b0);
        end

        for (int i = 0; i < N; i++) begin pv[i] = rnd16(); mv[i] = rnd16(); end
        mode = 1'b0; start = 1'b1; step(); start = 1'b0;
        serve("rp0", 0, 1, pv[0], 1'b0, 1'b0);
        serve("rm0", 0, 2, mv[0], 1'b0, 1'b0);
        take_grad(0, model_grad(pv[0], mv[0], 1'b0), 1'b0);
        serve("rp1", 1, 1, pv[1], 1'b0, 1'b0);
        t = 0;
        while (eval_req_valid !== 1'b1 && t < 50) begin step(); t++; end
        chk("rm1 req_dir", eval_dir, 2);
        eval_req_ready = 1'b1; step(); eval_req_ready = 1'b0;
        rst = 1'b0; step(); rst = 1'b1;
        eval_rsp_valid = 1'b1; eval_rsp_data = 16'd123;
        step();
        eval_rsp_valid = 1'b0;
        check_quiet("post_rst");
        step();
        check_quiet("post_rst_idle");

        for (int i = 0; i < N; i++) begin pv[i] = rnd16(); mv[i] = rnd16(); end
        sweep(1'b0, 1'b0, 1'b0);

        zero_latency(1'b0, 19);
        zero_latency(1'b1, 15);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
